// File: rtl/di_pkg.sv
// di_pkg: shared constants and FSM state type for the di_* register terminal.
//   DI_STAT_*        bit positions in di_transfer_status
//   DI_BAD_ADDR_DATA read data returned for an out-of-range register address
//   di_state_e       read/write handshake FSM states
package di_pkg;
  localparam int DI_STAT_TERM_MISMATCH = 0;
  localparam int DI_STAT_ADDR_RANGE    = 1;
  localparam int DI_STAT_RO_WRITE      = 2;
  localparam logic [31:0] DI_BAD_ADDR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_VALID,
    ST_WBUSY
  } di_state_e;
endpackage

// File: rtl/di_latency_timer.sv
// di_latency_timer: loadable 4-bit down-counter used to pace the read and
// write handshakes.
//   clk, reset_n  clock / async active-low reset
//   load          load load_val this cycle (takes priority over counting)
//   load_val      value to load
//   done          count has reached zero (idle counters sit at zero)
module di_latency_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 4'd1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/di_reg_terminal.sv
// di_reg_terminal: register bank answering one terminal address on the di_*
// bus behind the I2C slave host. Provides read/write-ready handshakes with
// programmable latency and reports errors on di_transfer_status.
//   di_term_addr/di_reg_addr   target terminal / register
//   di_read_mode/di_read_req/di_read   read transaction controls
//   di_write_mode/di_write/di_reg_datai  write transaction controls and data
//   di_read_rdy/di_reg_datao   read data valid / read data
//   di_write_rdy               ready to accept a write
//   di_transfer_status         sticky error flags (0 = OK)
//   ro_data                    sources for read-only slots
//   reg_q/reg_wr_stb           R/W register contents and update pulses
module di_reg_terminal
  import di_pkg::*;
#(
  parameter logic [15:0]            TERM_ADDR     = 16'h0050,
  parameter int                     NUM_REGS      = 16,
  parameter logic [NUM_REGS-1:0]    RO_MASK       = '0,
  parameter logic [NUM_REGS*32-1:0] RESET_VALUES  = '0,
  parameter int                     READ_LATENCY  = 2,
  parameter int                     WRITE_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [15:0]              di_term_addr,
  input  logic [31:0]              di_reg_addr,
  input  logic                     di_read_mode,
  input  logic                     di_read_req,
  input  logic                     di_read,
  input  logic                     di_write_mode,
  input  logic                     di_write,
  input  logic [31:0]              di_reg_datai,
  output logic                     di_read_rdy,
  output logic [31:0]              di_reg_datao,
  output logic                     di_write_rdy,
  output logic [15:0]              di_transfer_status,
  input  logic [NUM_REGS*32-1:0]   ro_data,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_stb
);
  localparam int IW = $clog2(NUM_REGS);

  di_state_e   state, state_nxt;
  logic [31:0] mem [NUM_REGS];
  logic [31:0] lat_addr;
  logic        lat_sel;
  logic        rd_pend, rd_pend_nxt;
  logic        rd_load, wr_load, rd_done, wr_done, fetch_cmp;
  logic [31:0] fetch_data;
  logic [2:0]  flags;

  // Current request decode
  wire          sel     = (di_term_addr == TERM_ADDR);
  wire          in_rng  = (di_reg_addr < 32'(NUM_REGS));
  wire [IW-1:0] idx     = di_reg_addr[IW-1:0];
  wire          is_ro   = in_rng && RO_MASK[idx];
  wire          active  = di_read_mode | di_write_mode | di_write | di_read_req;
  wire          any_evt = active | di_read;
  wire          wr_ok   = di_write && sel && in_rng && !is_ro;
  // An address change while read_mode is up re-triggers a fetch, so a
  // simultaneous read_req and address change is still a single fetch.
  wire          rd_trig = di_read_req | (di_read_mode && (di_reg_addr != lat_addr));

  // Latched fetch decode
  wire          lat_rng = (lat_addr < 32'(NUM_REGS));
  wire [IW-1:0] lat_idx = lat_addr[IW-1:0];

  always_comb begin
    fetch_data = '0;
    if (!lat_sel)              fetch_data = '0;
    else if (!lat_rng)         fetch_data = DI_BAD_ADDR_DATA;
    else if (RO_MASK[lat_idx]) fetch_data = ro_data[32*int'(lat_idx) +: 32];
    else                       fetch_data = mem[lat_idx];
  end

  always_comb begin
    flags = '0;
    flags[DI_STAT_TERM_MISMATCH] = active && !sel;
    flags[DI_STAT_ADDR_RANGE]    = active && !in_rng;
    flags[DI_STAT_RO_WRITE]      = di_write && is_ro;
  end

  di_latency_timer u_rd_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (rd_load),
    .load_val (4'(READ_LATENCY - 1)),
    .done     (rd_done)
  );

  di_latency_timer u_wr_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (wr_load),
    .load_val (4'(WRITE_LATENCY - 1)),
    .done     (wr_done)
  );

  // Writes always win; an interrupted read is remembered in rd_pend and
  // restarted once the write latency has elapsed.
  always_comb begin
    state_nxt   = state;
    rd_load     = 1'b0;
    wr_load     = 1'b0;
    fetch_cmp   = 1'b0;
    rd_pend_nxt = rd_pend;
    case (state)
      ST_IDLE: begin
        if (di_write) begin
          state_nxt = ST_WBUSY;
          wr_load   = 1'b1;
        end else if (rd_trig) begin
          state_nxt = ST_FETCH;
          rd_load   = 1'b1;
        end
      end
      ST_FETCH, ST_VALID: begin
        if (di_write) begin
          state_nxt   = ST_WBUSY;
          wr_load     = 1'b1;
          rd_pend_nxt = 1'b1;
        end else if (!di_read_mode && !di_read_req) begin
          state_nxt = ST_IDLE;
        end else if (rd_trig) begin
          state_nxt = ST_FETCH;
          rd_load   = 1'b1;
        end else if (state == ST_FETCH && rd_done) begin
          state_nxt = ST_VALID;
          fetch_cmp = 1'b1;
        end
      end
      ST_WBUSY: begin
        rd_pend_nxt = rd_pend | di_read_req;
        if (di_write) begin
          wr_load = 1'b1;
        end else if (wr_done) begin
          if (rd_pend || rd_trig) begin
            state_nxt = ST_FETCH;
            rd_load   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rd_load) rd_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      lat_addr           <= '0;
      lat_sel            <= 1'b0;
      rd_pend            <= 1'b0;
      di_reg_datao       <= '0;
      di_transfer_status <= '0;
      reg_wr_stb         <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= RO_MASK[i] ? 32'h0 : RESET_VALUES[i*32 +: 32];
    end else begin
      state      <= state_nxt;
      rd_pend    <= rd_pend_nxt;
      reg_wr_stb <= '0;
      if (rd_load) begin
        lat_addr <= di_reg_addr;
        lat_sel  <= sel;
      end
      if (fetch_cmp) di_reg_datao <= fetch_data;
      if (wr_ok) begin
        mem[idx]        <= di_reg_datai;
        reg_wr_stb[idx] <= 1'b1;
      end
      // Sticky for the whole transaction; clears once the bus goes quiet.
      if (!any_evt) di_transfer_status <= '0;
      else          di_transfer_status <= di_transfer_status | {13'b0, flags};
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[i*32 +: 32] = mem[i];
  end

  assign di_read_rdy  = (state == ST_VALID);
  assign di_write_rdy = (state != ST_WBUSY);
endmodule
